// File: rtl/tank_cmd_sequencer_pkg.sv
// Shared constants and types for the tank-game command sequencer.
package tank_cmd_sequencer_pkg;

  // Direction codes understood by the storage ALU.
  localparam logic [7:0] DIR_UP    = 8'h00;
  localparam logic [7:0] DIR_DOWN  = 8'h01;
  localparam logic [7:0] DIR_LEFT  = 8'h03;
  localparam logic [7:0] DIR_RIGHT = 8'h07;

  // Storage object-select codes. 4'b0000 is the RAM write and is never issued here.
  localparam logic [3:0] MODE_T1   = 4'b0001;
  localparam logic [3:0] MODE_P1   = 4'b0011;
  localparam logic [3:0] MODE_T2   = 4'b0101;
  localparam logic [3:0] MODE_P2   = 4'b0111;
  localparam logic [3:0] MODE_IDLE = 4'b1111;

  // Power-on positions, {col, row}.
  localparam logic [7:0] POS_RST_LO = 8'h00;
  localparam logic [7:0] POS_RST_HI = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_LOAD,
    ST_COMMIT,
    ST_CHECK,
    ST_DONE
  } state_e;

  // Lowest set bit of a slot mask as {found, index}.
  function automatic logic [2:0] first_slot(input logic [3:0] mask);
    logic [2:0] r;
    r = 3'b000;
    if (mask[0])      r = 3'b100;
    else if (mask[1]) r = 3'b101;
    else if (mask[2]) r = 3'b110;
    else if (mask[3]) r = 3'b111;
    return r;
  endfunction

endpackage

// File: rtl/tank_cmd_sequencer_dir_encode.sv
// Key vector {right, left, down, up} to direction code, priority up > down > left > right.
module dir_encode
  import tank_cmd_sequencer_pkg::*;
(
  input  logic [3:0] keys,
  output logic       valid,
  output logic [7:0] dir
);

  // Fixed-priority encode; no key pressed means no move this tick.
  always_comb begin
    valid = 1'b1;
    dir   = DIR_UP;
    if (keys[0])      dir = DIR_UP;
    else if (keys[1]) dir = DIR_DOWN;
    else if (keys[2]) dir = DIR_LEFT;
    else if (keys[3]) dir = DIR_RIGHT;
    else              valid = 1'b0;
  end

endmodule

// File: rtl/tank_cmd_sequencer.sv
// Per-tick command initiator: walks T1, P1, T2, P2 into storage, shadows
// the returned positions and reports projectile hits.
//
//   state     | meaning
//   ----------+----------------------------------------------------------
//   ST_IDLE   | waiting for tick; key latches accumulate
//   ST_ISSUE  | mode/data driven for the current slot (storage ALU registers)
//   ST_LOAD   | mode/data held, load_out strobed
//   ST_COMMIT | updated_pos captured into the slot shadow, advance slot
//   ST_CHECK  | projectile-vs-tank compare on the shadows
//   ST_DONE   | done pulse, hit pulses
module tank_cmd_sequencer
  import tank_cmd_sequencer_pkg::*;
#(
  parameter logic [3:0] IDLE_MODE = MODE_IDLE
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic [3:0] p1_move,
  input  logic       p1_fire,
  input  logic [3:0] p2_move,
  input  logic       p2_fire,
  input  logic [7:0] updated_pos,
  output logic [3:0] mode,
  output logic [7:0] data,
  output logic       load_out,
  output logic       busy,
  output logic       done,
  output logic       p1_hit,
  output logic       p2_hit,
  output logic       overrun
);

  state_e     state_q, state_d;
  logic [1:0] slot_q, slot_d;
  logic [3:0] en_q, en_d;
  logic [3:0] mv1_q, mv1_d, mv2_q, mv2_d;
  logic       fire1_q, fire1_d, fire2_q, fire2_d;
  logic [7:0] sdir1_q, sdir1_d, sdir2_q, sdir2_d;
  logic [7:0] t1_dir_q, t1_dir_d, t2_dir_q, t2_dir_d;
  logic [7:0] p1_dir_q, p1_dir_d, p2_dir_q, p2_dir_d;
  logic       p1_act_q, p1_act_d, p2_act_q, p2_act_d;
  logic [7:0] sh_t1_q, sh_t1_d, sh_p1_q, sh_p1_d;
  logic [7:0] sh_t2_q, sh_t2_d, sh_p2_q, sh_p2_d;
  logic       hit1_q, hit1_d, hit2_q, hit2_d;

  logic [3:0] keys1, keys2;
  logic       fire1_now, fire2_now;
  logic       v1, v2;
  logic [7:0] d1, d2;
  logic       f1_ok, f2_ok;
  logic [3:0] above_mask;
  logic [2:0] pick;
  logic [3:0] cur_mode;
  logic [7:0] cur_data;

  // The accepted tick sees everything latched so far plus this cycle's keys.
  assign keys1     = mv1_q | p1_move;
  assign keys2     = mv2_q | p2_move;
  assign fire1_now = fire1_q | p1_fire;
  assign fire2_now = fire2_q | p2_fire;

  dir_encode u_enc1 (.keys(keys1), .valid(v1), .dir(d1));
  dir_encode u_enc2 (.keys(keys2), .valid(v2), .dir(d2));

  // Current slot's select code and direction.
  always_comb begin
    cur_mode = MODE_T1;
    cur_data = sdir1_q;
    case (slot_q)
      2'd0: begin cur_mode = MODE_T1; cur_data = sdir1_q;  end
      2'd1: begin cur_mode = MODE_P1; cur_data = p1_dir_q; end
      2'd2: begin cur_mode = MODE_T2; cur_data = sdir2_q;  end
      default: begin cur_mode = MODE_P2; cur_data = p2_dir_q; end
    endcase
  end

  // Next-state, latch accumulation, shadow capture and hit detection.
  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    en_d     = en_q;
    mv1_d    = keys1;
    mv2_d    = keys2;
    fire1_d  = fire1_now;
    fire2_d  = fire2_now;
    sdir1_d  = sdir1_q;
    sdir2_d  = sdir2_q;
    t1_dir_d = t1_dir_q;
    t2_dir_d = t2_dir_q;
    p1_dir_d = p1_dir_q;
    p2_dir_d = p2_dir_q;
    p1_act_d = p1_act_q;
    p2_act_d = p2_act_q;
    sh_t1_d  = sh_t1_q;
    sh_p1_d  = sh_p1_q;
    sh_t2_d  = sh_t2_q;
    sh_p2_d  = sh_p2_q;
    hit1_d   = 1'b0;
    hit2_d   = 1'b0;
    f1_ok    = fire1_now & ~p1_act_q;
    f2_ok    = fire2_now & ~p2_act_q;
    above_mask = en_q & ~((4'd2 << slot_q) - 4'd1);
    pick     = first_slot(above_mask);

    case (state_q)
      ST_IDLE: begin
        if (tick) begin
          mv1_d   = 4'd0;
          mv2_d   = 4'd0;
          fire1_d = 1'b0;
          fire2_d = 1'b0;
          sdir1_d = d1;
          sdir2_d = d2;
          // A new projectile inherits the tank heading after this tick's move.
          if (f1_ok) begin
            p1_act_d = 1'b1;
            p1_dir_d = v1 ? d1 : t1_dir_q;
          end
          if (f2_ok) begin
            p2_act_d = 1'b1;
            p2_dir_d = v2 ? d2 : t2_dir_q;
          end
          en_d = {p2_act_q | f2_ok, v2, p1_act_q | f1_ok, v1};
          pick = first_slot(en_d);
          if (pick[2]) begin
            slot_d  = pick[1:0];
            state_d = ST_ISSUE;
          end else begin
            state_d = ST_CHECK;
          end
        end
      end
      ST_ISSUE: state_d = ST_LOAD;
      ST_LOAD:  state_d = ST_COMMIT;
      ST_COMMIT: begin
        case (slot_q)
          2'd0: begin
            sh_t1_d  = updated_pos;
            t1_dir_d = cur_data;
          end
          2'd1: begin
            sh_p1_d = updated_pos;
            if (updated_pos == sh_p1_q) p1_act_d = 1'b0;
          end
          2'd2: begin
            sh_t2_d  = updated_pos;
            t2_dir_d = cur_data;
          end
          default: begin
            sh_p2_d = updated_pos;
            if (updated_pos == sh_p2_q) p2_act_d = 1'b0;
          end
        endcase
        if (pick[2]) begin
          slot_d  = pick[1:0];
          state_d = ST_ISSUE;
        end else begin
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (p1_act_q && (sh_p1_q == sh_t2_q)) begin
          hit1_d   = 1'b1;
          p1_act_d = 1'b0;
        end
        if (p2_act_q && (sh_p2_q == sh_t1_q)) begin
          hit2_d   = 1'b1;
          p2_act_d = 1'b0;
        end
        state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Register update; reset aborts any sequence with no partial commit.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      slot_q   <= 2'd0;
      en_q     <= 4'd0;
      mv1_q    <= 4'd0;
      mv2_q    <= 4'd0;
      fire1_q  <= 1'b0;
      fire2_q  <= 1'b0;
      sdir1_q  <= DIR_DOWN;
      sdir2_q  <= DIR_UP;
      t1_dir_q <= DIR_DOWN;
      t2_dir_q <= DIR_UP;
      p1_dir_q <= DIR_DOWN;
      p2_dir_q <= DIR_UP;
      p1_act_q <= 1'b0;
      p2_act_q <= 1'b0;
      sh_t1_q  <= POS_RST_LO;
      sh_p1_q  <= POS_RST_LO;
      sh_t2_q  <= POS_RST_HI;
      sh_p2_q  <= POS_RST_HI;
      hit1_q   <= 1'b0;
      hit2_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      slot_q   <= slot_d;
      en_q     <= en_d;
      mv1_q    <= mv1_d;
      mv2_q    <= mv2_d;
      fire1_q  <= fire1_d;
      fire2_q  <= fire2_d;
      sdir1_q  <= sdir1_d;
      sdir2_q  <= sdir2_d;
      t1_dir_q <= t1_dir_d;
      t2_dir_q <= t2_dir_d;
      p1_dir_q <= p1_dir_d;
      p2_dir_q <= p2_dir_d;
      p1_act_q <= p1_act_d;
      p2_act_q <= p2_act_d;
      sh_t1_q  <= sh_t1_d;
      sh_p1_q  <= sh_p1_d;
      sh_t2_q  <= sh_t2_d;
      sh_p2_q  <= sh_p2_d;
      hit1_q   <= hit1_d;
      hit2_q   <= hit2_d;
    end
  end

  // Storage-facing outputs decode straight from the state register.
  always_comb begin
    mode     = IDLE_MODE;
    data     = 8'h00;
    load_out = 1'b0;
    if (state_q == ST_ISSUE || state_q == ST_LOAD || state_q == ST_COMMIT) begin
      mode = cur_mode;
      data = cur_data;
    end
    if (state_q == ST_LOAD) load_out = 1'b1;
    busy    = (state_q != ST_IDLE);
    done    = (state_q == ST_DONE);
    p1_hit  = hit1_q;
    p2_hit  = hit2_q;
    overrun = tick & (state_q != ST_IDLE);
  end

endmodule
